// File: rtl/snake_arbiter.sv
// Judges each snake move: wall/body collision, food capture, score, and re-placement
// of food on a pseudo-random free grid cell.
module snake_arbiter #(
    parameter int         X_MIN     = 144,
    parameter int         Y_MIN     = 64,
    parameter int         GRID      = 16,
    parameter int         COLS_LOG2 = 5,
    parameter int         ROWS_LOG2 = 4,
    parameter int         SEG_N     = 5,
    parameter int         FOOD_X0   = 272,
    parameter int         FOOD_Y0   = 128,
    parameter logic [9:0] LFSR_SEED = 10'h1A5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 update,
    input  logic [39:0]          head,
    input  logic [40*SEG_N-1:0]  body,
    output logic                 grow,
    output logic [39:0]          food,
    output logic [7:0]           score,
    output logic                 game_over,
    output logic                 busy
);

    localparam int         IDX_W  = $clog2(SEG_N + 1);
    localparam logic [9:0] GRID_W = 10'(GRID);
    localparam logic [9:0] X_LO   = 10'(X_MIN);
    localparam logic [9:0] X_HI   = 10'(X_MIN + (GRID << COLS_LOG2));
    localparam logic [9:0] Y_LO   = 10'(Y_MIN);
    localparam logic [9:0] Y_HI   = 10'(Y_MIN + (GRID << ROWS_LOG2));

    typedef enum logic [2:0] {
        IDLE, WAIT, SCAN, EVAL, PLACE, PCHK, OVER
    } state_t;

    state_t               state, state_n;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     seg_sel;
    logic                 hit_body;
    logic [9:0]           lfsr;
    logic [9:0]           cand_x, cand_y;
    logic [9:0]           col, row, cand_x_n, cand_y_n;
    logic [SEG_N-1:0][39:0] seg;
    logic [39:0]          cur;
    logic                 cur_valid;
    logic                 seg_vs_head, seg_vs_cand, head_vs_cand;
    logic                 wall, food_hit, pchk_hit;

    wire [9:0] head_x = head[19:10];
    wire [9:0] head_y = head[9:0];

    genvar g;
    generate
        for (g = 0; g < SEG_N; g++) begin : g_seg
            assign seg[g] = body[40*SEG_N-1-40*g -: 40];
        end
    endgenerate

    // PCHK spends idx 0 on the head, so segments are offset by one there.
    always_comb begin
        seg_sel = (state == PCHK) ? idx - IDX_W'(1) : idx;
        cur     = '0;
        for (int k = 0; k < SEG_N; k++)
            if (seg_sel == IDX_W'(k)) cur = seg[k];
    end

    assign cur_valid    = cur[39:30] != 10'd0;
    assign seg_vs_head  = cur_valid && cur[19:10] == head_x && cur[9:0] == head_y;
    assign seg_vs_cand  = cur_valid && cur[19:10] == cand_x && cur[9:0] == cand_y;
    assign head_vs_cand = head_x == cand_x && head_y == cand_y;
    assign pchk_hit     = (idx == '0) ? head_vs_cand : seg_vs_cand;

    assign wall = head_x < X_LO || head_x >= X_HI || head_y < Y_LO || head_y >= Y_HI;
    assign food_hit = head_x == food[19:10] && head_y == food[9:0];

    assign col      = 10'(lfsr[COLS_LOG2-1:0]);
    assign row      = 10'(lfsr[COLS_LOG2+ROWS_LOG2-1:COLS_LOG2]);
    assign cand_x_n = X_LO + GRID_W * col;
    assign cand_y_n = Y_LO + GRID_W * row;

    assign busy = state inside {WAIT, SCAN, EVAL, PLACE, PCHK};

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (update) state_n = WAIT;
            WAIT:  state_n = SCAN;
            SCAN:  if (idx == IDX_W'(SEG_N - 1)) state_n = EVAL;
            EVAL: begin
                if (wall || hit_body) state_n = OVER;
                else if (food_hit)    state_n = PLACE;
                else                  state_n = IDLE;
            end
            PLACE: state_n = PCHK;
            PCHK: begin
                if (pchk_hit)                     state_n = PLACE;
                else if (idx == IDX_W'(SEG_N))    state_n = IDLE;
            end
            OVER:  state_n = OVER;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            grow      <= 1'b0;
            score     <= 8'd0;
            game_over <= 1'b0;
            food      <= {GRID_W, GRID_W, 10'(FOOD_X0), 10'(FOOD_Y0)};
            lfsr      <= LFSR_SEED;
            idx       <= '0;
            hit_body  <= 1'b0;
            cand_x    <= '0;
            cand_y    <= '0;
        end else begin
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            case (state)
                IDLE: if (update) grow <= 1'b0;
                WAIT: begin
                    idx      <= '0;
                    hit_body <= 1'b0;
                end
                SCAN: begin
                    hit_body <= hit_body | seg_vs_head;
                    idx      <= idx + IDX_W'(1);
                end
                EVAL: begin
                    if (wall || hit_body) begin
                        game_over <= 1'b1;
                    end else if (food_hit) begin
                        grow  <= 1'b1;
                        score <= (score == 8'hFF) ? score : score + 8'd1;
                    end
                end
                PLACE: begin
                    cand_x <= cand_x_n;
                    cand_y <= cand_y_n;
                    idx    <= '0;
                end
                PCHK: begin
                    idx <= idx + IDX_W'(1);
                    if (!pchk_hit && idx == IDX_W'(SEG_N))
                        food <= {GRID_W, GRID_W, cand_x, cand_y};
                end
                OVER: grow <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_arbiter.sv
// Directed bench for snake_arbiter: food capture/placement, body and wall
// collisions, collision-vs-food priority, and reset in mid-scan.
module tb_snake_arbiter;

    localparam int         SEG_N = 5;
    localparam logic [9:0] SEED  = 10'h1A5;

    logic                clk, reset, update;
    logic [39:0]         head;
    logic [40*SEG_N-1:0] body;
    logic                grow, game_over, busy;
    logic [39:0]         food;
    logic [7:0]          score;

    int n_chk = 0;
    int n_pass = 0;
    logic [9:0] lm;

    snake_arbiter dut (
        .clk(clk), .reset(reset), .update(update), .head(head), .body(body),
        .grow(grow), .food(food), .score(score), .game_over(game_over), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // independent LFSR reference, used to predict where new food lands
    always @(posedge clk) lm <= !reset ? SEED : {lm[8:0], lm[9] ^ lm[6]};

    function automatic logic [39:0] box(input int x, input int y);
        return {10'd16, 10'd16, 10'(x), 10'(y)};
    endfunction

    function automatic logic [9:0] adv(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    task automatic chk(input string tag, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        update = 1'b1;
        step(1);
        update = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        body  = '0;
    endtask

    task automatic set_seg(input int k, input logic [39:0] v);
        body[40*SEG_N-1-40*k -: 40] = v;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            step(1);
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic wall_case(input string tag, input int x, input int y, input logic exp);
        do_reset();
        head = box(x, y);
        pulse();
        step(7);
        chk(tag, game_over, exp);
    endtask

    initial begin
        logic [9:0]  v;
        logic [39:0] exp_food, saved;
        int cx, cy;
        logic ok;

        reset = 1'b0; update = 1'b0; head = '0; body = '0;

        // reset values
        step(1);
        chk("rst_food", food, box(272, 128));
        chk("rst_score", score, 0);
        chk("rst_grow", grow, 0);
        chk("rst_go", game_over, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;

        // food capture, exact EVAL latency, LFSR-driven placement
        head = box(272, 128);
        pulse();
        chk("eat_busy", busy, 1);
        step(6);
        chk("eat_grow_t6", grow, 0);
        step(1);
        chk("eat_grow", grow, 1);
        chk("eat_score", score, 1);
        v = lm;
        cx = 144 + 16 * int'(v[4:0]);
        cy = 64 + 16 * int'(v[8:5]);
        while (cx == 272 && cy == 128) begin
            v  = adv(adv(v));
            cx = 144 + 16 * int'(v[4:0]);
            cy = 64 + 16 * int'(v[8:5]);
        end
        exp_food = box(cx, cy);
        wait_idle("place_timeout");
        chk("place_food", food, exp_food);
        ok = (food[13:10] == 0) && (food[3:0] == 0) && food[19:10] >= 144 && food[19:10] < 656
             && food[9:0] >= 64 && food[9:0] < 320 && !(food[19:10] == 272 && food[9:0] == 128);
        chk("place_range", ok, 1);
        pulse();
        chk("grow_clear", grow, 0);
        wait_idle("move_timeout");

        // body collision, then frozen outputs
        head = box(208, 96);
        body = '0;
        set_seg(2, box(208, 96));
        pulse();
        step(6);
        chk("body_go_t6", game_over, 0);
        step(1);
        chk("body_go", game_over, 1);
        chk("body_busy", busy, 0);
        saved = food;
        pulse();
        step(10);
        chk("over_score", score, 1);
        chk("over_grow", grow, 0);
        chk("over_food", food, saved);
        chk("over_busy", busy, 0);

        // wall boundaries
        wall_case("wall_x656", 656, 128, 1);
        wall_case("wall_x1008", 1008, 128, 1);
        wall_case("wall_y320", 400, 320, 1);
        wall_case("wall_x143", 143, 128, 1);
        do_reset();
        head = box(640, 304);
        set_seg(1, {10'd0, 10'd16, 10'd640, 10'd304});
        pulse();
        step(7);
        chk("edge_go", game_over, 0);
        chk("edge_busy", busy, 0);
        chk("edge_grow", grow, 0);

        // collision beats food on the same move
        do_reset();
        head = box(272, 128);
        set_seg(0, box(272, 128));
        pulse();
        step(7);
        chk("prio_go", game_over, 1);
        chk("prio_score", score, 0);
        chk("prio_grow", grow, 0);
        chk("prio_food", food, box(272, 128));

        // reset mid-scan, then a clean move
        do_reset();
        head = box(272, 128);
        pulse();
        step(2);
        chk("scan_busy", busy, 1);
        reset = 1'b0;
        step(1);
        chk("mid_busy", busy, 0);
        chk("mid_grow", grow, 0);
        chk("mid_score", score, 0);
        chk("mid_go", game_over, 0);
        chk("mid_food", food, box(272, 128));
        reset = 1'b1;
        pulse();
        step(7);
        chk("after_grow", grow, 1);
        chk("after_score", score, 1);
        wait_idle("after_timeout");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
